// File: rtl/mio_arbiter.sv
// mio_arbiter
// Two-master arbiter/sequencer for the shared memory/MIO bus. Port 0 is the
// multi-cycle CPU controller, port 1 is the DMA/peripheral engine. Accesses
// are serialised onto one registered memory handshake; an access with no
// acknowledge within TIMEOUT cycles is aborted and flagged.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata      CPU request (level, held until cpu_ready)
//   cpu_rdata, cpu_ready       CPU read data / MIO_ready stall (low = stall)
//   dma_req/we/addr/wdata      DMA request (level, held until dma_done)
//   dma_rdata, dma_done        DMA read data / one-cycle completion pulse
//   mem_req/we/addr/wdata      registered memory request
//   mem_rdata, mem_ack         memory read data / one-cycle completion
//   grant                      current owner (00 none, 01 CPU, 10 DMA);
//                              this is the FSM state itself
//   timeout_err, err_clr       sticky abort flag and its synchronous clear
//
// Handshake: a master raises req with stable we/addr/wdata and holds them
// until its completion (cpu_ready high with cpu_req high, or dma_done).
// Completion is signalled for exactly one cycle; a request still high in
// the cycle after completion is a new transaction.
module mio_arbiter #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ready,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [31:0]   dma_wdata,
  output logic [31:0]   dma_rdata,
  output logic          dma_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic [1:0]    grant,
  output logic          timeout_err,
  input  logic          err_clr
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CPU_ACC = 2'b01,
    DMA_ACC = 2'b10
  } state_t;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_dma_q, last_dma_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [31:0]     cpu_rdata_q, cpu_rdata_d;
  logic [31:0]     dma_rdata_q, dma_rdata_d;
  logic            cpu_done_q, cpu_done_d;
  logic            dma_done_q, dma_done_d;
  logic            err_q, err_d;

  logic            cpu_elig, dma_elig, pick_dma;
  logic            at_limit, finish, err_set;
  logic [31:0]     done_data;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_dma_d  = last_dma_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_done_d  = 1'b0;
    dma_done_d  = 1'b0;
    err_set     = 1'b0;

    // A master whose done pulse is high this cycle is still holding its old
    // request; it must not be restarted until the following cycle.
    cpu_elig = cpu_req & ~cpu_done_q;
    dma_elig = dma_req & ~dma_done_q;
    // Round-robin on a tie: DMA only if the CPU is not eligible or was last.
    pick_dma = dma_elig & (~cpu_elig | ~last_dma_q);

    at_limit  = (cnt_q == CNT_LAST);
    // An ack on the limit cycle wins over the timeout.
    finish    = mem_ack | at_limit;
    done_data = mem_ack ? mem_rdata : 32'h0;

    unique case (state_q)
      IDLE: begin
        if (cpu_elig | dma_elig) begin
          state_d     = pick_dma ? DMA_ACC : CPU_ACC;
          last_dma_d  = pick_dma;
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          mem_we_d    = pick_dma ? dma_we    : cpu_we;
          mem_addr_d  = pick_dma ? dma_addr  : cpu_addr;
          mem_wdata_d = pick_dma ? dma_wdata : cpu_wdata;
        end
      end
      CPU_ACC, DMA_ACC: begin
        if (finish) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          err_set   = ~mem_ack;
          if (state_q == DMA_ACC) begin
            dma_done_d = 1'b1;
            if (!mem_we_q) dma_rdata_d = done_data;
          end else begin
            cpu_done_d = 1'b1;
            if (!mem_we_q) cpu_rdata_d = done_data;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // A new timeout takes priority over a coincident clear.
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_dma_q  <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      dma_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_dma_q  <= last_dma_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_done_q  <= cpu_done_d;
      dma_done_q  <= dma_done_d;
      err_q       <= err_d;
    end
  end

  assign grant       = state_q;
  assign cpu_ready   = ~cpu_req | cpu_done_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign dma_rdata   = dma_rdata_q;
  assign dma_done    = dma_done_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// Testbench for mio_arbiter: memory responder with per-transaction latency,
// bus-transaction and read-data scoreboards, directed scenarios, then a
// random serial phase.
module tb_mio_arbiter;
  localparam int AW = 32;

  logic          clk, reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata, cpu_rdata;
  logic          cpu_ready;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [31:0]   dma_wdata, dma_rdata;
  logic          dma_done;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_ack;
  logic [1:0]    grant;
  logic          timeout_err, err_clr;

  mio_arbiter #(.AW(AW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .grant(grant), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic        m;      // 0 CPU, 1 DMA
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;  // data the memory returns on ack
    int          lat;    // ack on this ACC cycle (1-based), 0 = never
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] cpu_exp_q[$];
  logic [31:0] dma_exp_q[$];
  logic [31:0] cpu_shadow = 32'h0;
  logic [31:0] dma_shadow = 32'h0;

  // Record one transaction: the bus access it should produce, and the read
  // data the master should hold when it completes (timeout reads give 0,
  // writes leave the previous value).
  task automatic expect_txn(input logic m, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int lat);
    bus_t e;
    logic [31:0] r;
    e.m = m; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.lat = lat;
    bus_q.push_back(e);
    r = (lat == 0) ? 32'h0 : rdata;
    if (m == 1'b0) begin
      if (!we) cpu_shadow = r;
      cpu_exp_q.push_back(cpu_shadow);
    end else begin
      if (!we) dma_shadow = r;
      dma_exp_q.push_back(dma_shadow);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin : mem_model
    int   acc;
    bus_t cur;
    acc = 0;
    cur = '{default: 0};
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (reset || !mem_req) begin
        acc = 0;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
      end else begin
        acc++;
        if (acc == 1) begin
          chk("bus_txn_expected", (bus_q.size() != 0), 1);
          if (bus_q.size() != 0) begin
            cur = bus_q.pop_front();
            chk("bus_grant", grant, cur.m ? 2'b10 : 2'b01);
            chk("bus_we", mem_we, cur.we);
            chk("bus_addr", mem_addr, cur.addr);
            if (cur.we) chk("bus_wdata", mem_wdata, cur.wdata);
          end
        end
        mem_ack = (cur.lat != 0) && (acc == cur.lat);
        mem_rdata = mem_ack ? cur.rdata : $urandom;
      end
    end
  end

  // ---------------- completion monitor ----------------
  initial begin : done_monitor
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (cpu_req && cpu_ready) begin
          chk("cpu_done_expected", (cpu_exp_q.size() != 0), 1);
          if (cpu_exp_q.size() != 0) chk("cpu_rdata", cpu_rdata, cpu_exp_q.pop_front());
        end
        if (dma_done) begin
          chk("dma_done_expected", (dma_exp_q.size() != 0), 1);
          if (dma_exp_q.size() != 0) chk("dma_rdata", dma_rdata, dma_exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge. Returns the number of stall cycles
  // (cpu_ready low) and timeout_err as seen in the completion cycle.
  task automatic cpu_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int lat, input logic hold,
                         output int stalls, output logic err_done);
    logic seen;
    expect_txn(1'b0, we, addr, wdata, rdata, lat);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    stalls = 0; seen = 1'b0; err_done = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (cpu_ready) seen = 1'b1;
      else stalls++;
    end
    chk("cpu_txn_completes", seen, 1);
    chk("cpu_done_grant_idle", grant, 2'b00);
    err_done = timeout_err;
    @(posedge clk); #1;
    if (!hold) cpu_req = 1'b0;
  endtask

  task automatic dma_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int lat,
                         output int cycles, output logic err_done);
    logic seen;
    expect_txn(1'b1, we, addr, wdata, rdata, lat);
    dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
    cycles = 0; seen = 1'b0; err_done = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (dma_done) seen = 1'b1;
      else cycles++;
    end
    chk("dma_txn_completes", seen, 1);
    chk("dma_done_grant_idle", grant, 2'b00);
    err_done = timeout_err;
    @(posedge clk); #1;
    dma_req = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int   n;
    logic e;
    logic [1:0] exp_grant [9];

    reset = 1'b1; err_clr = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;

    // Reset state
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_cpu_ready", cpu_ready, 1);
    chk("rst_dma_done", dma_done, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Simultaneous requests: CPU first, then alternation while both held
    expect_txn(1'b0, 1'b0, 32'h100, 32'h0, 32'hA1A1_0001, 1);
    expect_txn(1'b1, 1'b0, 32'h200, 32'h0, 32'hB2B2_0002, 1);
    expect_txn(1'b0, 1'b0, 32'h100, 32'h0, 32'hA1A1_0003, 1);
    expect_txn(1'b1, 1'b0, 32'h200, 32'h0, 32'hB2B2_0004, 1);
    cpu_we = 1'b0; cpu_addr = 32'h100; cpu_req = 1'b1;
    dma_we = 1'b0; dma_addr = 32'h200; dma_req = 1'b1;
    exp_grant = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("rr_grant_%0d", i), grant, exp_grant[i]);
      @(posedge clk); #1;
      if (i == 6) cpu_req = 1'b0;
      if (i == 8) dma_req = 1'b0;
    end

    // CPU read alone: ack on 3rd ACC cycle -> 4 stall cycles
    cpu_txn(1'b0, 32'h10, 32'h0, 32'h1234_5678, 3, 1'b0, n, e);
    chk("cpu_read_stalls", n, 4);

    // Contention: DMA write in progress, CPU request waits
    expect_txn(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 32'h0, 5);
    dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'hCAFE_F00D; dma_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= 5) begin
        chk("cont_dma_grant", grant, 2'b10);
        chk("cont_dma_addr", mem_addr, 32'h20);
        chk("cont_dma_we", mem_we, 1);
      end
      if (i == 6) begin
        chk("cont_dma_done", dma_done, 1);
        chk("cont_idle_gap", grant, 2'b00);
      end
      if (i == 7) begin
        chk("cont_cpu_grant", grant, 2'b01);
        chk("cont_cpu_addr", mem_addr, 32'h40);
        chk("cont_cpu_we", mem_we, 0);
      end
      if (i == 9) chk("cont_cpu_ready", cpu_ready, 1);
      @(posedge clk); #1;
      if (i == 1) begin
        expect_txn(1'b0, 1'b0, 32'h40, 32'h0, 32'h0BAD_CAFE, 2);
        cpu_we = 1'b0; cpu_addr = 32'h40; cpu_req = 1'b1;
      end
      if (i == 6) dma_req = 1'b0;
      if (i == 9) cpu_req = 1'b0;
    end

    // Ack exactly on the limit cycle: normal completion, no error
    cpu_txn(1'b0, 32'h30, 32'h0, 32'h5555_AAAA, 16, 1'b0, n, e);
    chk("limit_ack_stalls", n, 17);
    chk("limit_ack_no_err", e, 0);

    // Timeout on a DMA read
    dma_txn(1'b0, 32'h50, 32'h0, 32'hFFFF_FFFF, 0, n, e);
    chk("timeout_cycles", n, 17);
    chk("timeout_err_set", e, 1);
    @(negedge clk);
    chk("timeout_err_sticky", timeout_err, 1);
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    @(negedge clk);
    chk("timeout_err_cleared", timeout_err, 0);
    @(posedge clk); #1;

    // Timeout while err_clr is held: set wins, then clear applies
    err_clr = 1'b1;
    cpu_txn(1'b0, 32'h60, 32'h0, 32'h1111_2222, 0, 1'b0, n, e);
    chk("set_wins_cycles", n, 17);
    chk("set_wins_err", e, 1);
    @(negedge clk);
    chk("clr_after_set", timeout_err, 0);
    @(posedge clk); #1; err_clr = 1'b0;

    // Reset mid-access: lost transaction, then fresh access
    bus_q.push_back('{m: 1'b0, we: 1'b0, addr: 32'h80, wdata: 32'h0, rdata: 32'h0, lat: 0});
    cpu_we = 1'b0; cpu_addr = 32'h80; cpu_req = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("mid_grant", grant, 2'b01);
    chk("mid_mem_req", mem_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_mem_req", mem_req, 0);
    chk("async_grant", grant, 2'b00);
    chk("async_cpu_ready", cpu_ready, 0);
    cpu_shadow = 32'h0; dma_shadow = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    cpu_txn(1'b0, 32'h84, 32'h0, 32'h7777_8888, 2, 1'b0, n, e);
    chk("post_reset_stalls", n, 3);

    // Held request after completion is a fresh access one cycle later
    cpu_txn(1'b1, 32'h90, 32'hDEAD_BEEF, 32'h0, 1, 1'b1, n, e);
    chk("held_first_stalls", n, 2);
    cpu_txn(1'b0, 32'h90, 32'h0, 32'h2468_ACE0, 1, 1'b0, n, e);
    chk("held_second_stalls", n, 2);

    // Random serial traffic from both masters
    for (int k = 0; k < 12; k++) begin
      logic        we;
      logic [31:0] a, wd, rd;
      int          lat;
      we  = 1'($urandom_range(0, 1));
      a   = $urandom;
      wd  = $urandom;
      rd  = $urandom;
      lat = $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 0) cpu_txn(we, a, wd, rd, lat, 1'b0, n, e);
      else                           dma_txn(we, a, wd, rd, lat, n, e);
      chk("rand_latency", n, lat + 1);
      chk("rand_no_err", e, 0);
    end

    repeat (2) @(negedge clk);
    chk("bus_q_drained", bus_q.size(), 0);
    chk("cpu_exp_drained", cpu_exp_q.size(), 0);
    chk("dma_exp_drained", dma_exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time bound so the run always ends
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule
